// File: rtl/arb_memory.sv
// rtl/arb_memory.sv - round-robin arbitrated multi-port single-bank memory with power-up clear sweep
// Memory is zeroed by a one-word-per-cycle sweep after reset; requests are only served afterwards.
module arb_memory #(
   parameter int AddrSize = 8,
   parameter int DataSize = 32,
   parameter int NumPorts = 2,
   localparam int Lanes = DataSize / 8,
   localparam int PW = (NumPorts > 2) ? $clog2(NumPorts) : 1
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [NumPorts-1:0]          Valid,
   input  logic [NumPorts-1:0]          R_W,
   input  logic [NumPorts*AddrSize-1:0] Addr,
   input  logic [NumPorts*DataSize-1:0] Din,
   input  logic [NumPorts*Lanes-1:0]    ByteEn,
   output logic [NumPorts-1:0]          Ready,
   output logic [DataSize-1:0]          Dout,
   output logic                         DoutValid,
   output logic [PW-1:0]                DoutPort,
   output logic                         InitDone
);

   localparam int Depth = 2 ** AddrSize;

   typedef enum logic {INIT, RUN} state_t;

   state_t                state, next_state;
   logic [AddrSize:0]     init_cnt;
   logic [PW-1:0]         rr;
   logic [PW-1:0]         gnt_idx;
   logic                  gnt_any;
   logic                  xfer;
   logic [AddrSize-1:0]   g_addr;
   logic [DataSize-1:0]   g_din;
   logic [Lanes-1:0]      g_be;
   logic                  g_write;
   logic [DataSize-1:0]   mem [Depth];

   function automatic logic [PW-1:0] wrap_idx(input int v);
      return PW'(v % NumPorts);
   endfunction

   // First valid port at or above rr, wrapping modulo NumPorts.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NumPorts; k++) begin
         if (!gnt_any && Valid[wrap_idx(int'(rr) + k)]) begin
            gnt_any = 1'b1;
            gnt_idx = wrap_idx(int'(rr) + k);
         end
      end
   end

   always_comb begin
      next_state = state;
      Ready      = '0;
      xfer       = 1'b0;
      case (state)
         INIT: begin
            if (init_cnt == (AddrSize + 1)'(Depth - 1))
               next_state = RUN;
         end
         RUN: begin
            if (gnt_any) begin
               Ready[gnt_idx] = 1'b1;
               xfer           = 1'b1;
            end
         end
         default: next_state = INIT;
      endcase
   end

   assign g_addr  = Addr[int'(gnt_idx) * AddrSize +: AddrSize];
   assign g_din   = Din[int'(gnt_idx) * DataSize +: DataSize];
   assign g_be    = ByteEn[int'(gnt_idx) * Lanes +: Lanes];
   assign g_write = R_W[gnt_idx];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= INIT;
         init_cnt <= '0;
         rr       <= '0;
         InitDone <= 1'b0;
      end else begin
         state <= next_state;
         if (state == INIT)
            init_cnt <= init_cnt + 1'b1;
         if (state == INIT && next_state == RUN)
            InitDone <= 1'b1;
         if (xfer)
            rr <= wrap_idx(int'(gnt_idx) + 1);
      end
   end

   // Storage has no reset; only the INIT sweep clears it.
   always_ff @(posedge Clk) begin
      if (state == INIT) begin
         mem[init_cnt[AddrSize-1:0]] <= '0;
      end else if (xfer && g_write) begin
         for (int i = 0; i < Lanes; i++)
            if (g_be[i])
               mem[g_addr][8*i +: 8] <= g_din[8*i +: 8];
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Dout      <= '0;
         DoutValid <= 1'b0;
         DoutPort  <= '0;
      end else begin
         DoutValid <= 1'b0;
         if (xfer && !g_write) begin
            Dout      <= mem[g_addr];
            DoutPort  <= gnt_idx;
            DoutValid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_arb_memory.sv
// tb/tb_arb_memory.sv - self-checking bench for arb_memory against a behavioural arbitration/memory model
module tb_arb_memory;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [1:0]  Valid;
   logic [1:0]  R_W;
   logic [15:0] Addr;
   logic [63:0] Din;
   logic [7:0]  ByteEn;
   logic [1:0]  Ready;
   logic [31:0] Dout;
   logic        DoutValid;
   logic        DoutPort;
   logic        InitDone;

   int tests = 0;
   int failures = 0;

   logic [31:0] mem_m [256];
   int          rr_m;
   logic [31:0] dout_m;
   logic        dport_m;
   logic        dvalid_m;

   arb_memory dut (
      .Clk(Clk), .Reset(Reset), .Valid(Valid), .R_W(R_W), .Addr(Addr), .Din(Din),
      .ByteEn(ByteEn), .Ready(Ready), .Dout(Dout), .DoutValid(DoutValid),
      .DoutPort(DoutPort), .InitDone(InitDone)
   );

   always #5 Clk = ~Clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
      rr_m = 0; dout_m = 32'h0; dport_m = 1'b0; dvalid_m = 1'b0;
   endtask

   // Called at posedge+1: drives one cycle of requests, checks the grant, then the registered result.
   task automatic do_cycle(input logic [1:0] v, input logic [1:0] rw,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [3:0] be0, input logic [3:0] be1);
      int          g;
      logic [1:0]  exp_ready;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  be;
      Valid = v; R_W = rw; Addr = {a1, a0}; Din = {d1, d0}; ByteEn = {be1, be0};
      #1;
      g = -1;
      for (int k = 0; k < 2; k++)
         if (g < 0 && v[(rr_m + k) % 2]) g = (rr_m + k) % 2;
      exp_ready = (g < 0) ? 2'b00 : (2'b01 << g);
      check("ready", {62'h0, Ready}, {62'h0, exp_ready});
      if (g >= 0) begin
         a  = (g == 1) ? a1 : a0;
         d  = (g == 1) ? d1 : d0;
         be = (g == 1) ? be1 : be0;
         if (rw[g]) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
            dvalid_m = 1'b0;
         end else begin
            dout_m   = mem_m[a];
            dport_m  = (g == 1);
            dvalid_m = 1'b1;
         end
         rr_m = (g + 1) % 2;
      end else begin
         dvalid_m = 1'b0;
      end
      @(posedge Clk); #1;
      check("dout_valid", {63'h0, DoutValid}, {63'h0, dvalid_m});
      check("dout", {32'h0, Dout}, {32'h0, dout_m});
      check("dout_port", {63'h0, DoutPort}, {63'h0, dport_m});
   endtask

   // Called at posedge+1 right after Reset drops; requests stay asserted to show they are ignored.
   task automatic init_sweep(input string tag);
      int cycles = 0;
      int bad = 0;
      Valid = 2'b11; R_W = 2'b00;
      #1;
      while (!InitDone && cycles < 400) begin
         if (Ready !== 2'b00) bad++;
         @(posedge Clk); #1;
         cycles++;
      end
      Valid = 2'b00;
      check({tag, "_ready_zero"}, 64'(bad), 64'd0);
      check({tag, "_cycles"}, 64'(cycles), 64'd256);
      check({tag, "_initdone"}, {63'h0, InitDone}, 64'd1);
   endtask

   function automatic logic [7:0] pick_addr();
      logic [7:0] lo;
      lo = 8'($urandom_range(0, 7));
      return ($urandom_range(0, 1) == 1) ? (8'hF8 | lo) : lo;
   endfunction

   initial begin
      Reset = 1'b1; Valid = '0; R_W = '0; Addr = '0; Din = '0; ByteEn = '0;
      model_reset();
      repeat (3) @(posedge Clk);
      #1;
      check("rst_ready", {62'h0, Ready}, 64'd0);
      check("rst_dout_valid", {63'h0, DoutValid}, 64'd0);
      check("rst_dout", {32'h0, Dout}, 64'd0);
      check("rst_dout_port", {63'h0, DoutPort}, 64'd0);
      check("rst_initdone", {63'h0, InitDone}, 64'd0);
      Reset = 1'b0;
      init_sweep("init1");

      for (int a = 0; a < 256; a++)
         do_cycle(2'b01, 2'b00, 8'(a), 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);

      do_cycle(2'b01, 2'b01, 8'h10, 8'h0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
      do_cycle(2'b01, 2'b00, 8'h10, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      check("full_write_dout", {32'h0, Dout}, 64'hDEADBEEF);
      check("full_write_port", {63'h0, DoutPort}, 64'd0);

      do_cycle(2'b10, 2'b10, 8'h0, 8'h10, 32'h0, 32'h11223344, 4'h0, 4'h5);
      do_cycle(2'b10, 2'b00, 8'h0, 8'h10, 32'h0, 32'h0, 4'h0, 4'h0);
      check("lane_write_dout", {32'h0, Dout}, 64'hDE22BE44);
      check("lane_write_port", {63'h0, DoutPort}, 64'd1);

      for (int i = 0; i < 4; i++) begin
         do_cycle(2'b11, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, 4'h0, 4'h0);
         check("alternate_port", {63'h0, DoutPort}, 64'(i % 2));
      end

      do_cycle(2'b10, 2'b10, 8'h0, 8'hFF, 32'h0, 32'hCAFEF00D, 4'h0, 4'hF);
      do_cycle(2'b10, 2'b00, 8'h0, 8'hFF, 32'h0, 32'h0, 4'h0, 4'h0);
      check("top_addr_dout", {32'h0, Dout}, 64'hCAFEF00D);

      do_cycle(2'b01, 2'b01, 8'hFF, 8'h0, 32'h12345678, 32'h0, 4'h0, 4'h0);
      do_cycle(2'b01, 2'b00, 8'hFF, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      check("zero_be_dout", {32'h0, Dout}, 64'hCAFEF00D);

      for (int n = 0; n < 400; n++)
         do_cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  pick_addr(), pick_addr(), $urandom, $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      Valid = 2'b01; R_W = 2'b00; Addr = {8'h0, 8'hFF};
      #2;
      Reset = 1'b1;
      #1;
      check("midrun_dout_valid", {63'h0, DoutValid}, 64'd0);
      check("midrun_dout", {32'h0, Dout}, 64'd0);
      check("midrun_initdone", {63'h0, InitDone}, 64'd0);
      check("midrun_ready", {62'h0, Ready}, 64'd0);
      @(posedge Clk); #1;
      check("midrun_hold_valid", {63'h0, DoutValid}, 64'd0);
      Reset = 1'b0;
      model_reset();
      init_sweep("init2");
      for (int i = 0; i < 8; i++) begin
         do_cycle(2'b01, 2'b00, 8'hF8 + 8'(i), 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
         do_cycle(2'b10, 2'b00, 8'h0, 8'(i), 32'h0, 32'h0, 4'h0, 4'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
